ser_frame_tx: RTL and testbench



---
 rtl/ser_pkg.sv | 18 +
 rtl/ser_bit_mux.sv | 21 ++
 rtl/ser_frame_tx.sv | 149 ++++++++++++++
 tb/tb_ser_frame_tx.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// rtl/ser_pkg.sv - shared state encoding, length clamp and default width for ser_frame_tx
package ser_pkg;

  localparam int DEFAULT_DATA_W = 40;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_e;

  // A zero or oversized request means "send the whole word".
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned data_w);
    if (len == 0 || len > data_w) return data_w;
    return len;
  endfunction

endpackage

// File: rtl/ser_bit_mux.sv
// rtl/ser_bit_mux.sv - parametrised combinational bit selector (generalised fixed-width selector)
module ser_bit_mux
  import ser_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int IDX_W  = $clog2(DATA_W + 1)
) (
  input  logic [DATA_W-1:0] data,
  input  logic [IDX_W-1:0]  idx,
  output logic              sel_bit
);

  // Out-of-range indices select 0 rather than X.
  always_comb begin
    sel_bit = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (idx == IDX_W'(i)) sel_bit = data[i];
    end
  end

endmodule

// File: rtl/ser_frame_tx.sv
// rtl/ser_frame_tx.sv - parallel-to-serial frame transmitter, LSB/MSB first, tick-paced
// Optional even-parity trailer bit when SER_PARITY_EN is defined.
module ser_frame_tx
  import ser_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic [CNT_W-1:0]  len,
  input  logic              msb_first,
  input  logic              load,
  output logic              ready,
  input  logic              tick,
  output logic              out,
  output logic              out_valid,
  output logic              done
);

  ser_state_e        state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  sel_idx;
  logic              msb_q, msb_d;
  logic              out_d, valid_d, done_d;
  logic              last_bit, mux_bit;
`ifdef SER_PARITY_EN
  logic              par_q, par_d;
`endif

  assign ready    = (state_q == IDLE);
  assign last_bit = (idx_q == len_q - CNT_W'(1));

  always_comb begin : next_state
    state_d = state_q;
    data_d  = data_q;
    len_d   = len_q;
    msb_d   = msb_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
`ifdef SER_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = SHIFT;
          data_d  = data;
          len_d   = CNT_W'(clamp_len(32'(len), DATA_W));
          msb_d   = msb_first;
          idx_d   = '0;
`ifdef SER_PARITY_EN
          par_d   = 1'b0;
`endif
        end
      end
      SHIFT: begin
        if (tick) begin
`ifdef SER_PARITY_EN
          // out holds the bit being consumed, so fold it in before moving on
          par_d = par_q ^ out;
`endif
          if (last_bit) begin
            idx_d = '0;
`ifdef SER_PARITY_EN
            state_d = PARITY;
`else
            state_d = IDLE;
            done_d  = 1'b1;
`endif
          end else begin
            idx_d = idx_q + CNT_W'(1);
          end
        end
      end
      default: begin
        if (tick) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  // The serial bit is registered, so it is selected from the next-state word and index.
  assign sel_idx = msb_d ? (len_d - CNT_W'(1) - idx_d) : idx_d;

  ser_bit_mux #(
    .DATA_W (DATA_W),
    .IDX_W  (CNT_W)
  ) u_bit_mux (
    .data    (data_d),
    .idx     (sel_idx),
    .sel_bit (mux_bit)
  );

  always_comb begin : next_out
    out_d   = 1'b0;
    valid_d = 1'b0;
    case (state_d)
      SHIFT: begin
        out_d   = mux_bit;
        valid_d = 1'b1;
      end
`ifdef SER_PARITY_EN
      PARITY: begin
        out_d   = par_d;
        valid_d = 1'b1;
      end
`endif
      default: begin
        out_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      data_q    <= '0;
      len_q     <= '0;
      msb_q     <= 1'b0;
      idx_q     <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
`ifdef SER_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      len_q     <= len_d;
      msb_q     <= msb_d;
      idx_q     <= idx_d;
      out       <= out_d;
      out_valid <= valid_d;
      done      <= done_d;
`ifdef SER_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_ser_frame_tx.sv
// tb/tb_ser_frame_tx.sv - self-checking bench for ser_frame_tx (honours SER_PARITY_EN)
module tb_ser_frame_tx;

  localparam int DW = 40;
  localparam int CW = $clog2(DW + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] data = '0;
  logic [CW-1:0] len = '0;
  logic          msb_first = 1'b0;
  logic          load = 1'b0;
  logic          tick = 1'b1;
  logic          ready, out, out_valid, done;

  int n_cmp = 0;
  int n_err = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  ser_frame_tx #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .data      (data),
    .len       (len),
    .msb_first (msb_first),
    .load      (load),
    .ready     (ready),
    .tick      (tick),
    .out       (out),
    .out_valid (out_valid),
    .done      (done)
  );

  // Reference: frame bits in transmission order, plus even parity when enabled.
  function automatic void model_frame(input logic [DW-1:0] d, input int l, input bit m);
    int n;
    int ones;
    logic [DW-1:0] sh;
    n = (l == 0 || l > DW) ? DW : l;
    ones = 0;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      sh = m ? (d >> (n - 1 - i)) : (d >> i);
      exp_q.push_back(sh[0]);
      if (sh[0]) ones++;
    end
`ifdef SER_PARITY_EN
    exp_q.push_back(bit'(ones % 2));
`endif
  endfunction

  task automatic add_parity_literal(input bit p);
`ifdef SER_PARITY_EN
    exp_q.push_back(p);
`endif
  endtask

  // Starts a frame at the current negedge and walks it to the done cycle against exp_q.
  task automatic drive_frame(input logic [DW-1:0] d, input logic [CW-1:0] l, input bit m,
                             input int mode, input bit junk);
    int i, cyc, hold;
    bit t;
    n_cmp++;
    if ({ready, out_valid, out} !== 3'b100) begin
      n_err++;
      $display("FAIL start_idle: ready/out_valid/out=%b%b%b required 100", ready, out_valid, out);
    end
    data = d; len = l; msb_first = m; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    i = 0; cyc = 0; hold = 0;
    while (i < exp_q.size() && cyc < 2000) begin
      n_cmp++;
      if ({out_valid, out, done} !== {1'b1, exp_q[i], 1'b0}) begin
        n_err++;
        $display("FAIL frame_bit[%0d] cyc %0d: valid/out/done=%b%b%b required 1%b0",
                 i, cyc, out_valid, out, done, exp_q[i]);
      end
      if (mode == 0) t = 1'b1;
      else if (mode == 1) t = (cyc % 3 == 2);
      else t = (hold >= 4) ? 1'b1 : bit'($urandom_range(0, 1));
      hold = t ? 0 : hold + 1;
      tick = t;
      if (junk) begin
        load = bit'($urandom_range(0, 1));
        data = DW'({$urandom, $urandom});
        len = CW'($urandom);
        msb_first = bit'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (t) i++;
      cyc++;
    end
    load = 1'b0; tick = 1'b1;
    n_cmp++;
    if (cyc >= 2000) begin
      n_err++;
      $display("FAIL frame_timeout: %0d of %0d bits seen, required all", i, exp_q.size());
    end
    n_cmp++;
    if ({done, ready, out_valid, out} !== 4'b1100) begin
      n_err++;
      $display("FAIL frame_end: done/ready/valid/out=%b%b%b%b required 1100", done, ready, out_valid, out);
    end
  endtask

  task automatic check_idle_after(input string name);
    @(negedge clk);
    n_cmp++;
    if ({done, ready, out_valid} !== 3'b010) begin
      n_err++;
      $display("FAIL %s: done/ready/valid=%b%b%b required 010", name, done, ready, out_valid);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({ready, out_valid, out, done} !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_state: ready/valid/out/done=%b%b%b%b required 1000", ready, out_valid, out, done);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lsb();
    exp_q = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    add_parity_literal(1'b0);
    drive_frame(40'hA5, CW'(8), 1'b0, 0, 1'b0);
    check_idle_after("lsb_done_once");
  endtask

  task automatic test_msb();
    exp_q = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    add_parity_literal(1'b0);
    drive_frame(40'hA5, CW'(8), 1'b1, 0, 1'b0);
    check_idle_after("msb_a5_done_once");
    exp_q = '{1'b0, 1'b0, 1'b0, 1'b1};
    add_parity_literal(1'b1);
    drive_frame(40'h01, CW'(4), 1'b1, 0, 1'b0);
    check_idle_after("msb_01_done_once");
  endtask

  task automatic test_len_zero();
    exp_q.delete();
    exp_q.push_back(1'b1);
    for (int i = 0; i < 38; i++) exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    add_parity_literal(1'b0);
    drive_frame(40'h80_0000_0001, CW'(0), 1'b0, 0, 1'b0);
    check_idle_after("len0_done_once");
  endtask

  task automatic test_slow_tick();
    exp_q = '{1'b1, 1'b0, 1'b1};
    add_parity_literal(1'b0);
    drive_frame(40'h5, CW'(3), 1'b0, 1, 1'b1);
    for (int k = 0; k < 4; k++) check_idle_after("slow_tick_done_once");
  endtask

  task automatic test_mid_reset();
    logic [DW-1:0] d;
    d = DW'({$urandom, $urandom});
    model_frame(d, 8, 1'b0);
    data = d; len = CW'(8); msb_first = 1'b0; load = 1'b1; tick = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({out_valid, out} !== {1'b1, exp_q[i]}) begin
        n_err++;
        $display("FAIL pre_reset_bit[%0d]: valid/out=%b%b required 1%b", i, out_valid, out, exp_q[i]);
      end
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({ready, out_valid, out, done} !== 4'b1000) begin
      n_err++;
      $display("FAIL mid_reset: ready/valid/out/done=%b%b%b%b required 1000", ready, out_valid, out, done);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) check_idle_after("post_reset_no_done");
    d = DW'({$urandom, $urandom});
    model_frame(d, 8, 1'b1);
    drive_frame(d, CW'(8), 1'b1, 0, 1'b0);
    check_idle_after("post_reset_frame");
  endtask

  task automatic test_back_to_back();
    exp_q = '{1'b1, 1'b1, 1'b1};
    add_parity_literal(1'b1);
    drive_frame(40'h07, CW'(3), 1'b0, 0, 1'b0);
    model_frame(40'hA5, 8, 1'b1);
    drive_frame(40'hA5, CW'(8), 1'b1, 0, 1'b0);
    check_idle_after("b2b_done_once");
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    int l;
    bit m;
    for (int f = 0; f < 40; f++) begin
      d = DW'({$urandom, $urandom});
      l = int'($urandom_range(0, 45));
      m = bit'($urandom_range(0, 1));
      model_frame(d, l, m);
      drive_frame(d, CW'(l), m, int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 0) check_idle_after("random_done_once");
    end
    check_idle_after("random_final");
  endtask

  initial begin
    test_reset();
    test_lsb();
    test_msb();
    test_len_zero();
    test_slow_tick();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
